// File: rtl/mult_share_arbiter_if.sv
// Request/response bundle between the requesting datapath blocks and the
// shared-multiplier scheduler.
interface mult_share_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
);
  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ-1:0]   req_ready;
  logic [4*NUM_REQ-1:0] req_a;
  logic [4*NUM_REQ-1:0] req_b;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [ID_W-1:0]      rsp_id;
  logic [7:0]           rsp_product;

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_product
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_product
  );
endinterface

// File: rtl/mult_share_arbiter.sv
// Round-robin scheduler sharing one combinational 4x4 multiplier among
// NUM_REQ requesters; one operation in flight at a time.
module mult_share_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                clk,
  input  logic                rst,
  mult_share_arbiter_if.slave bus,
  output logic [3:0]          mul_a,
  output logic [3:0]          mul_b,
  input  logic [7:0]          mul_product,
  output logic                busy
);
  localparam int unsigned NR = NUM_REQ;

  typedef enum logic [1:0] {IDLE, MUL, RESP} state_t;

  state_t             state;
  logic [ID_W-1:0]    rr_ptr;
  logic [ID_W-1:0]    id_reg;
  logic [ID_W-1:0]    gnt_idx;
  logic [ID_W-1:0]    gnt_next;
  logic               gnt_found;
  logic [NUM_REQ-1:0] gnt_vec;
  logic [ID_W-1:0]    rsp_id_q;
  logic [7:0]         rsp_product_q;

  // Scan upward from rr_ptr with wrap; first asserted valid wins.
  always_comb begin
    int unsigned pos;
    pos       = 0;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int unsigned k = 0; k < NR; k++) begin
      pos = 32'(rr_ptr) + k;
      if (pos >= NR) pos = pos - NR;
      if (!gnt_found && bus.req_valid[ID_W'(pos)]) begin
        gnt_found = 1'b1;
        gnt_idx   = ID_W'(pos);
      end
    end
  end

  always_comb begin
    gnt_vec = '0;
    if (state == IDLE && gnt_found) gnt_vec[gnt_idx] = 1'b1;
  end

  assign gnt_next = (gnt_idx == ID_W'(NR - 1)) ? '0 : gnt_idx + ID_W'(1);

  assign bus.req_ready   = gnt_vec;
  assign bus.rsp_valid   = (state == RESP);
  assign bus.rsp_id      = rsp_id_q;
  assign bus.rsp_product = rsp_product_q;
  assign busy            = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      rr_ptr        <= '0;
      id_reg        <= '0;
      mul_a         <= '0;
      mul_b         <= '0;
      rsp_id_q      <= '0;
      rsp_product_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          // The winner's ready is already high, so a found grant is a handshake.
          if (gnt_found) begin
            mul_a  <= bus.req_a[{gnt_idx, 2'b00} +: 4];
            mul_b  <= bus.req_b[{gnt_idx, 2'b00} +: 4];
            id_reg <= gnt_idx;
            rr_ptr <= gnt_next;
            state  <= MUL;
          end
        end
        MUL: begin
          rsp_product_q <= mul_product;
          rsp_id_q      <= id_reg;
          state         <= RESP;
        end
        RESP: begin
          if (bus.rsp_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mult_share_arbiter.sv
// Scoreboard bench for mult_share_arbiter: accepted requests push expected
// {id, product}; taken responses are compared against them.
module tb_mult_share_arbiter;
  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] mul_a;
  logic [3:0] mul_b;
  logic [7:0] mul_product;
  logic       busy;

  int checks = 0;
  int passes = 0;

  logic [9:0]         exp_q[$];
  logic [9:0]         act_q[$];
  int                 grant_q[$];
  logic [NUM_REQ-1:0] acc = '0;

  mult_share_arbiter_if #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) bus();

  mult_share_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .mul_a(mul_a), .mul_b(mul_b), .mul_product(mul_product), .busy(busy)
  );

  // Reference shared multiplier
  assign mul_product = {4'b0, mul_a} * {4'b0, mul_b};

  always #5 clk = ~clk;

  // Monitor: handshakes seen here complete on the following rising edge.
  logic [NUM_REQ-1:0]   prev_valid, prev_ready;
  logic [4*NUM_REQ-1:0] prev_a, prev_b;
  logic                 prev_live = 1'b0;
  always @(negedge clk) begin
    logic [3:0] oa, ob;
    acc = '0;
    if (!rst) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (bus.req_valid[i] && bus.req_ready[i]) begin
          oa = bus.req_a[4*i +: 4];
          ob = bus.req_b[4*i +: 4];
          acc[i] = 1'b1;
          exp_q.push_back({2'(i), {4'b0, oa} * {4'b0, ob}});
          grant_q.push_back(i);
        end
        if (prev_live && prev_valid[i] && !prev_ready[i])
          assert (bus.req_valid[i] && bus.req_a[4*i +: 4] == prev_a[4*i +: 4]
                  && bus.req_b[4*i +: 4] == prev_b[4*i +: 4])
            else $error("requester %0d withdrew or changed a pending request", i);
      end
      if (bus.rsp_valid && bus.rsp_ready) act_q.push_back({bus.rsp_id, bus.rsp_product});
    end
    prev_live  = !rst;
    prev_valid = bus.req_valid;
    prev_ready = bus.req_ready;
    prev_a     = bus.req_a;
    prev_b     = bus.req_b;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Accept responses and retire each request once granted until all is quiet.
  task automatic drain(input int unsigned budget, output bit to);
    int unsigned n;
    n  = 0;
    to = 1'b0;
    bus.rsp_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      bus.req_valid = bus.req_valid & ~acc;
      if (bus.req_valid == '0 && !busy && exp_q.size() == act_q.size()) break;
      n++;
      if (n >= budget) begin to = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    bit to;
    logic [9:0] e, a;
    rst = 1'b1;
    bus.req_valid = '1;
    bus.req_a = '0;
    bus.req_b = '0;
    bus.rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (bus.rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid got %0b want 0", bus.rsp_valid); else passes++;
    checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %0b want 0", busy); else passes++;
    checks++; if ({mul_a, mul_b} !== 8'h00) $display("FAIL reset_mul_ops got %h/%h want 0/0", mul_a, mul_b); else passes++;
    checks++; if ({bus.rsp_id, bus.rsp_product} !== 10'h000) $display("FAIL reset_rsp_regs got %0d/%0d want 0/0", bus.rsp_id, bus.rsp_product); else passes++;
    rst = 1'b0;
    @(negedge clk);
    checks++; if (bus.req_ready !== 4'b0001) $display("FAIL reset_first_grant got %b want 0001", bus.req_ready); else passes++;
    drain(60, to);
    checks++; if (to) $display("FAIL reset_drain timeout got busy=%0b want idle", busy); else passes++;
    while (exp_q.size() > 0 && act_q.size() > 0) begin
      e = exp_q.pop_front(); a = act_q.pop_front(); checks++;
      if (a !== e) $display("FAIL reset_sb got id=%0d p=%0d want id=%0d p=%0d", a[9:8], a[7:0], e[9:8], e[7:0]); else passes++;
    end
    checks++; if (exp_q.size() != 0 || act_q.size() != 0) $display("FAIL reset_sb_count got %0d want %0d", act_q.size(), exp_q.size()); else passes++;
    exp_q.delete(); act_q.delete();
  endtask

  task automatic test_single_op();
    bit to;
    int n;
    logic [9:0] e, a;
    bus.rsp_ready = 1'b1;
    bus.req_a[11:8] = 4'd13;
    bus.req_b[11:8] = 4'd11;
    bus.req_valid[2] = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.req_ready[2] && n < 10);
    checks++; if (bus.req_ready[2] !== 1'b1) $display("FAIL single_grant got %b want 0100", bus.req_ready); else passes++;
    @(posedge clk); #1;
    bus.req_valid[2] = 1'b0;
    @(negedge clk);
    checks++; if ({bus.rsp_valid, busy} !== 2'b01) $display("FAIL single_mul_cycle got valid=%0b busy=%0b want 0/1", bus.rsp_valid, busy); else passes++;
    @(negedge clk);
    checks++; if (bus.rsp_valid !== 1'b1) $display("FAIL single_latency got %0b want 1", bus.rsp_valid); else passes++;
    checks++; if ({bus.rsp_id, bus.rsp_product} !== {2'd2, 8'd143}) $display("FAIL single_result got %0d/%0d want 2/143", bus.rsp_id, bus.rsp_product); else passes++;
    drain(20, to);
    checks++; if (to) $display("FAIL single_drain timeout got busy=%0b want idle", busy); else passes++;
    while (exp_q.size() > 0 && act_q.size() > 0) begin
      e = exp_q.pop_front(); a = act_q.pop_front(); checks++;
      if (a !== e) $display("FAIL single_sb got id=%0d p=%0d want id=%0d p=%0d", a[9:8], a[7:0], e[9:8], e[7:0]); else passes++;
    end
    checks++; if (exp_q.size() != 0 || act_q.size() != 0) $display("FAIL single_sb_count got %0d want %0d", act_q.size(), exp_q.size()); else passes++;
    exp_q.delete(); act_q.delete();
  endtask

  task automatic test_full_range();
    bit to, stuck;
    int n;
    logic [7:0] xv;
    logic [9:0] e, a;
    stuck = 1'b0;
    bus.rsp_ready = 1'b1;
    for (int x = 0; x < 256; x++) begin
      xv = 8'(x);
      bus.req_a[3:0] = xv[7:4];
      bus.req_b[3:0] = xv[3:0];
      bus.req_valid[0] = 1'b1;
      n = 0;
      do begin @(posedge clk); #1; n++; end while (!acc[0] && n < 20);
      if (!acc[0]) begin stuck = 1'b1; break; end
      bus.req_valid[0] = 1'b0;
    end
    checks++; if (stuck) $display("FAIL range_issue stalled got no grant want grant"); else passes++;
    drain(40, to);
    checks++; if (to) $display("FAIL range_drain timeout got busy=%0b want idle", busy); else passes++;
    while (exp_q.size() > 0 && act_q.size() > 0) begin
      e = exp_q.pop_front(); a = act_q.pop_front(); checks++;
      if (a !== e) $display("FAIL range_sb got id=%0d p=%0d want id=%0d p=%0d", a[9:8], a[7:0], e[9:8], e[7:0]); else passes++;
    end
    checks++; if (exp_q.size() != 0 || act_q.size() != 0) $display("FAIL range_sb_count got %0d want %0d", act_q.size(), exp_q.size()); else passes++;
    exp_q.delete(); act_q.delete();
  endtask

  task automatic test_round_robin();
    bit to;
    int n;
    logic [9:0] e, a;
    @(posedge clk); #1;
    rst = 1'b1;
    bus.req_valid = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    grant_q.delete();
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) begin
      bus.req_a[4*i +: 4] = 4'($urandom);
      bus.req_b[4*i +: 4] = 4'($urandom);
    end
    bus.req_valid = '1;
    n = 0;
    while (grant_q.size() < 8 && n < 100) begin
      @(posedge clk); #1; n++;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (acc[i]) begin
          bus.req_a[4*i +: 4] = 4'($urandom);
          bus.req_b[4*i +: 4] = 4'($urandom);
        end
      end
    end
    drain(60, to);
    checks++; if (to || n >= 100) $display("FAIL rr_progress timeout got %0d grants want 12", grant_q.size()); else passes++;
    checks++; if (grant_q.size() != 12) $display("FAIL rr_grant_count got %0d want 12", grant_q.size()); else passes++;
    for (int k = 0; k < grant_q.size() && k < 12; k++) begin
      checks++;
      if (grant_q[k] != k % NUM_REQ) $display("FAIL rr_order[%0d] got %0d want %0d", k, grant_q[k], k % NUM_REQ); else passes++;
    end
    while (exp_q.size() > 0 && act_q.size() > 0) begin
      e = exp_q.pop_front(); a = act_q.pop_front(); checks++;
      if (a !== e) $display("FAIL rr_sb got id=%0d p=%0d want id=%0d p=%0d", a[9:8], a[7:0], e[9:8], e[7:0]); else passes++;
    end
    checks++; if (exp_q.size() != 0 || act_q.size() != 0) $display("FAIL rr_sb_count got %0d want %0d", act_q.size(), exp_q.size()); else passes++;
    exp_q.delete(); act_q.delete();
  endtask

  task automatic test_backpressure();
    bit to;
    int n;
    logic [9:0] e, a;
    bus.rsp_ready = 1'b0;
    bus.req_a[7:4] = 4'd7;
    bus.req_b[7:4] = 4'd9;
    bus.req_valid[1] = 1'b1;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!acc[1] && n < 10);
    checks++; if (!acc[1]) $display("FAIL bp_grant got %b want 0010", acc); else passes++;
    bus.req_valid[1] = 1'b0;
    bus.req_a[15:12] = 4'd2;
    bus.req_b[15:12] = 4'd6;
    bus.req_valid[3] = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++; if (bus.rsp_valid !== 1'b1) $display("FAIL bp_valid[%0d] got %0b want 1", k, bus.rsp_valid); else passes++;
      checks++; if ({bus.rsp_id, bus.rsp_product} !== {2'd1, 8'd63}) $display("FAIL bp_hold[%0d] got %0d/%0d want 1/63", k, bus.rsp_id, bus.rsp_product); else passes++;
      checks++; if (bus.req_ready !== 4'b0000) $display("FAIL bp_ready[%0d] got %b want 0000", k, bus.req_ready); else passes++;
    end
    @(posedge clk); #1;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    checks++; if ({bus.rsp_valid, bus.req_ready} !== 5'b1_0000) $display("FAIL bp_accept_cycle got valid=%0b ready=%b want 1/0000", bus.rsp_valid, bus.req_ready); else passes++;
    @(posedge clk); #1;
    checks++; if ({busy, bus.rsp_valid} !== 2'b00) $display("FAIL bp_return_idle got busy=%0b valid=%0b want 0/0", busy, bus.rsp_valid); else passes++;
    @(negedge clk);
    checks++; if (bus.req_ready !== 4'b1000) $display("FAIL bp_next_grant got %b want 1000", bus.req_ready); else passes++;
    drain(20, to);
    checks++; if (to) $display("FAIL bp_drain timeout got busy=%0b want idle", busy); else passes++;
    while (exp_q.size() > 0 && act_q.size() > 0) begin
      e = exp_q.pop_front(); a = act_q.pop_front(); checks++;
      if (a !== e) $display("FAIL bp_sb got id=%0d p=%0d want id=%0d p=%0d", a[9:8], a[7:0], e[9:8], e[7:0]); else passes++;
    end
    checks++; if (exp_q.size() != 0 || act_q.size() != 0) $display("FAIL bp_sb_count got %0d want %0d", act_q.size(), exp_q.size()); else passes++;
    exp_q.delete(); act_q.delete();
  endtask

  task automatic test_reset_mid_op();
    bit to;
    int n;
    logic [9:0] e, a;
    bus.rsp_ready = 1'b1;
    bus.req_a[11:8] = 4'd5;
    bus.req_b[11:8] = 4'd5;
    bus.req_valid[2] = 1'b1;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!acc[2] && n < 10);
    checks++; if (!acc[2]) $display("FAIL midrst_grant got %b want 0100", acc); else passes++;
    // Now in MUL: the accepted operation is to be discarded by reset.
    bus.req_valid[2] = 1'b0;
    rst = 1'b1;
    if (exp_q.size() > 0) void'(exp_q.pop_back());
    bus.req_a[3:0] = 4'd3;   bus.req_b[3:0] = 4'd4;
    bus.req_a[15:12] = 4'd9; bus.req_b[15:12] = 4'd8;
    bus.req_valid[0] = 1'b1;
    bus.req_valid[3] = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++; if ({busy, bus.rsp_valid} !== 2'b00) $display("FAIL midrst_idle got busy=%0b valid=%0b want 0/0", busy, bus.rsp_valid); else passes++;
    grant_q.delete();
    @(negedge clk);
    checks++; if (bus.req_ready !== 4'b0001) $display("FAIL midrst_next_grant got %b want 0001", bus.req_ready); else passes++;
    drain(30, to);
    checks++; if (to) $display("FAIL midrst_drain timeout got busy=%0b want idle", busy); else passes++;
    checks++; if (grant_q.size() != 2 || grant_q[0] != 0 || grant_q[1] != 3) $display("FAIL midrst_order got %0d grants first=%0d want 2 grants 0,3", grant_q.size(), grant_q.size() > 0 ? grant_q[0] : -1); else passes++;
    while (exp_q.size() > 0 && act_q.size() > 0) begin
      e = exp_q.pop_front(); a = act_q.pop_front(); checks++;
      if (a !== e) $display("FAIL midrst_sb got id=%0d p=%0d want id=%0d p=%0d", a[9:8], a[7:0], e[9:8], e[7:0]); else passes++;
    end
    checks++; if (exp_q.size() != 0 || act_q.size() != 0) $display("FAIL midrst_sb_count got %0d want %0d", act_q.size(), exp_q.size()); else passes++;
    exp_q.delete(); act_q.delete();
  endtask

  initial begin
    test_reset();
    test_single_op();
    test_full_range();
    test_round_robin();
    test_backpressure();
    test_reset_mid_op();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
